// File: rtl/haraka_s_sponge_if.sv
// Message-in and squeeze-out streams of the Haraka-S sponge controller.
// The master side produces message blocks and consumes squeezed blocks.
interface haraka_s_sponge_if;
    logic [255:0] msg_data;
    logic [5:0]   msg_bytes;
    logic         msg_last;
    logic         msg_valid;
    logic         msg_ready;
    logic [255:0] out_data;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output msg_data, msg_bytes, msg_last, msg_valid, out_ready,
        input  msg_ready, out_data, out_last, out_valid
    );

    modport slave (
        input  msg_data, msg_bytes, msg_last, msg_valid, out_ready,
        output msg_ready, out_data, out_last, out_valid
    );
endinterface

// File: rtl/haraka_s_sponge.sv
// Haraka-S sponge controller: pads and absorbs 256-bit rate blocks, steps the external
// round core through one permutation per block, then squeezes 256-bit output blocks.
//
// state      | meaning
// ST_ABSORB  | waiting for a message block, or absorbing the internal pad-only block
// ST_PERM    | permutation running, perm_cnt_q counts 0..L-1
// ST_SQUEEZE | out_valid held with state[255:0] until the consumer accepts
module haraka_s_sponge #(
    parameter int ROUNDS       = 5,
    parameter int ROUND_CYCLES = 2,
    parameter int OUT_BLOCKS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    haraka_s_sponge_if.slave bus,
    output logic [511:0]     core_in,
    output logic             core_sel,
    input  logic [511:0]     core_out
);
    localparam int L  = ROUNDS * ROUND_CYCLES;
    localparam int CW = $clog2(L + 1);
    localparam int SW = $clog2(OUT_BLOCKS + 1);
    localparam logic [CW-1:0] PERM_LAST = CW'(L - 1);
    localparam logic [SW-1:0] SQ_LAST   = SW'(OUT_BLOCKS - 1);
    localparam logic [255:0]  PAD_BLOCK = {8'h80, 240'h0, 8'h1F};

    typedef enum logic [1:0] {
        ST_ABSORB  = 2'd0,
        ST_PERM    = 2'd1,
        ST_SQUEEZE = 2'd2
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [CW-1:0] perm_cnt_q;
    logic [SW-1:0] sq_cnt_q;
    logic [511:0]  state_q;
    logic          pad_pending_q;
    logic          last_q;
    logic          armed_q;

    logic [5:0]    n_bytes;
    logic [255:0]  blk;
    logic          blk_full;
    logic          msg_fire;
    logic          out_fire;
    logic          perm_done;

    assign msg_fire  = bus.msg_valid & bus.msg_ready;
    assign out_fire  = bus.out_valid & bus.out_ready;
    assign perm_done = (fsm_q == ST_PERM) && (perm_cnt_q == PERM_LAST);

    // A full last block gets its padding from a separate pad-only block afterwards.
    always_comb begin
        n_bytes  = (bus.msg_bytes > 6'd32) ? 6'd32 : bus.msg_bytes;
        blk      = bus.msg_data;
        blk_full = 1'b0;
        if (bus.msg_last) begin
            blk_full = (n_bytes == 6'd32);
            for (int i = 0; i < 32; i++) begin
                if (6'(i) >= n_bytes) blk[8*i +: 8] = 8'h00;
                if (6'(i) == n_bytes) blk[8*i +: 8] = 8'h1F;
            end
            if (!blk_full) blk[255:248] = blk[255:248] ^ 8'h80;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= ST_ABSORB;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_ABSORB: begin
                if (pad_pending_q || msg_fire) fsm_d = ST_PERM;
            end
            ST_PERM: begin
                if (perm_done) begin
                    if (pad_pending_q)  fsm_d = ST_ABSORB;
                    else if (last_q)    fsm_d = ST_SQUEEZE;
                    else                fsm_d = ST_ABSORB;
                end
            end
            ST_SQUEEZE: begin
                if (out_fire) fsm_d = bus.out_last ? ST_ABSORB : ST_PERM;
            end
            default: fsm_d = ST_ABSORB;
        endcase
    end

    always_comb begin
        bus.msg_ready = armed_q && (fsm_q == ST_ABSORB) && !pad_pending_q;
        core_sel      = (fsm_q == ST_PERM) && (perm_cnt_q != '0);
        bus.out_valid = (fsm_q == ST_SQUEEZE);
        bus.out_last  = (fsm_q == ST_SQUEEZE) && (sq_cnt_q == SQ_LAST);
        bus.out_data  = (fsm_q == ST_SQUEEZE) ? state_q[255:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q       <= 1'b0;
            state_q       <= '0;
            core_in       <= '0;
            perm_cnt_q    <= '0;
            sq_cnt_q      <= '0;
            pad_pending_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (fsm_q)
                ST_ABSORB: begin
                    if (pad_pending_q) begin
                        core_in       <= {state_q[511:256], state_q[255:0] ^ PAD_BLOCK};
                        pad_pending_q <= 1'b0;
                        perm_cnt_q    <= '0;
                    end else if (msg_fire) begin
                        core_in       <= {state_q[511:256], state_q[255:0] ^ blk};
                        pad_pending_q <= blk_full;
                        last_q        <= bus.msg_last;
                        sq_cnt_q      <= '0;
                        perm_cnt_q    <= '0;
                    end
                end
                ST_PERM: begin
                    if (perm_done) begin
                        state_q    <= core_out;
                        perm_cnt_q <= '0;
                    end else begin
                        perm_cnt_q <= perm_cnt_q + CW'(1);
                    end
                end
                ST_SQUEEZE: begin
                    if (out_fire) begin
                        if (bus.out_last) begin
                            state_q  <= '0;
                            last_q   <= 1'b0;
                            sq_cnt_q <= '0;
                        end else begin
                            // extra squeeze block: permute the state with nothing absorbed
                            sq_cnt_q   <= sq_cnt_q + SW'(1);
                            core_in    <= state_q;
                            perm_cnt_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
